// File: rtl/riscv_pkg.sv
// Shared RV32I encoding definitions: opcode values matching the immediate generator,
// shift funct3 codes, and a sign-extension range helper used by the optional imm checks.
package riscv_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    // True when v is representable as a two's-complement value of 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = $unsigned($signed(v) >>> (bits - 1));
        return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Opcode-to-word packing for RV32I; range checks when IMM_RANGE_CHECK_EN is defined.
// Latency: combinational. Backpressure: none (pure function of its inputs).
module instr_pack
    import riscv_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        valid_fmt,
    output logic        range_ok
);

    logic is_shift;

    always_comb begin
        instr     = '0;
        valid_fmt = 1'b1;
        range_ok  = 1'b1;
        is_shift  = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
        case (opcode_e'(opcode))
            OP_REG:
                instr = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_IMM: begin
                if (is_shift) begin
                    instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
                    range_ok = (imm[31:5] == '0);
`endif
                end else begin
                    instr = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
                    range_ok = fits_signed(imm, 12);
`endif
                end
            end
            OP_LOAD, OP_JALR: begin
                instr = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
                range_ok = fits_signed(imm, 12);
`endif
            end
            OP_STORE: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef IMM_RANGE_CHECK_EN
                range_ok = fits_signed(imm, 12);
`endif
            end
            OP_BRANCH: begin
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef IMM_RANGE_CHECK_EN
                range_ok = fits_signed(imm, 13) && !imm[0];
`endif
            end
            OP_LUI, OP_AUIPC: begin
                instr = {imm[31:12], rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
                range_ok = (imm[11:0] == '0);
`endif
            end
            OP_JAL: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
                range_ok = fits_signed(imm, 21) && !imm[0];
`endif
            end
            default:
                valid_fmt = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder feeding instruction memory; IMM_RANGE_CHECK_EN enables imm checks.
// Latency: 1 cycle accept-to-out_valid. Backpressure: in_ready = !out_valid || out_ready.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              err_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    logic [31:0] packed_word;
    logic        valid_fmt;
    logic        range_ok;
    logic        accept;
    logic        good;
    logic        xfer;

    instr_pack u_pack (
        .opcode    (in_opcode),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .funct3    (in_funct3),
        .funct7    (in_funct7),
        .imm       (in_imm),
        .instr     (packed_word),
        .valid_fmt (valid_fmt),
        .range_ok  (range_ok)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign good     = valid_fmt && range_ok;
    assign xfer     = out_valid && out_ready;

    // A bad request still occupies the accept slot, so it can clear out_valid on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE_ADDR;
            err       <= 1'b0;
        end else begin
            if (accept && good) begin
                out_valid <= 1'b1;
                out_instr <= packed_word;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            if (xfer)
                out_addr <= out_addr + 1'b1;
            if (accept && !good)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, backpressure, errors, address wrap, async reset.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready_s;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        err_clr;
    logic        out_valid, out_valid_s;
    logic        out_ready;
    logic [31:0] out_instr, out_instr_s;
    logic [9:0]  out_addr;
    logic [1:0]  out_addr_s;
    logic        err, err_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(10'd0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .err_clr(err_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .err(err)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .err_clr(err_clr), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_instr(out_instr_s), .out_addr(out_addr_s), .err(err_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_addr",  out_addr, 0);
        check("rst_err",       err, 0);
        check("rst_in_ready",  in_ready, 1);
        #11 rst = 1'b0;

        // ADDI x1,x0,5 visible one cycle after accept
        out_ready = 1'b1;
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5);
        check("addi_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("addi_valid", out_valid, 1);
        check("addi_instr", out_instr, 32'h0050_0093);
        check("addi_addr",  out_addr, 0);
        do_reset();

        // Back-to-back stream at addresses 0..3
        set_req(7'h23, 5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'd8);
        tick();
        check("sw_instr", out_instr, 32'h0020_A423);
        check("sw_addr",  out_addr, 0);
        set_req(7'h63, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_FFFC);
        tick();
        check("beq_instr", out_instr, 32'hFE00_0EE3);
        check("beq_addr",  out_addr, 1);
        set_req(7'h6F, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2048);
        tick();
        check("jal_instr", out_instr, 32'h0010_00EF);
        check("jal_addr",  out_addr, 2);
        set_req(7'h37, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h1234_5000);
        tick();
        check("lui_instr", out_instr, 32'h1234_52B7);
        check("lui_addr",  out_addr, 3);
        check("lui_valid", out_valid, 1);

        // Stall three cycles with a competing request offered
        out_ready = 1'b0;
        set_req(7'h13, 5'd7, 5'd0, 5'd0, 3'b000, 7'h00, 32'd1);
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_in_ready", in_ready, 0);
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_instr", out_instr, 32'h1234_52B7);
            check("hold_addr",  out_addr, 3);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("release_valid", out_valid, 0);
        check("release_addr",  out_addr, 4);
        tick();
        check("release_addr_once", out_addr, 4);

        // Unknown opcode, then err_clr colliding with a new bad request
        set_req(7'h7F, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd0);
        tick();
        in_valid = 1'b0;
        check("badop_valid", out_valid, 0);
        check("badop_err",   err, 1);
        check("badop_addr",  out_addr, 4);
        err_clr = 1'b1;
        tick();
        check("errclr_err", err, 0);
        set_req(7'h7F, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd0);
        tick();
        in_valid = 1'b0;
        check("set_wins_err", err, 1);
        tick();
        err_clr = 1'b0;
        check("errclr2_err", err, 0);

        // ADDI with out-of-range immediate 4096
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd4096);
        tick();
        in_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        check("range_valid", out_valid, 0);
        check("range_err",   err, 1);
        check("range_addr",  out_addr, 4);
`else
        check("trunc_valid", out_valid, 1);
        check("trunc_instr", out_instr, 32'h0000_0093);
        check("trunc_err",   err, 0);
        check("trunc_addr",  out_addr, 4);
        tick();
        check("trunc_drain_addr", out_addr, 5);
`endif

        // 2-bit address counter wraps after four transfers
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, i);
            tick();
            check("wrap_addr", out_addr_s, i % 4);
        end
        check("wrap_last_instr", out_instr_s, 32'h0040_0093);

        // Async reset with a stalled word and err set
        set_req(7'h7F, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd0);
        tick();
        check("pre_rst_err", err, 1);
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        check("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_addr",  out_addr, 0);
        check("arst_err",   err, 0);
        check("arst_instr", out_instr, 0);
        #3 rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields plus a full 32-bit immediate and emits the packed 32-bit instruction word. It is the inverse of the core's immediate generator and decode path. It sits in the test/boot path, feeding instruction memory with an auto-incrementing word address. The output stage is registered behind a valid/ready handshake, and a sticky error flag reports unencodable requests.

## Interface
- ADDR_W, 10, width of the output word-address counter
- BASE_ADDR, 0, address of the first emitted word after reset (ADDR_W bits)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept request
- in_opcode  in  7  RV32I opcode (R, I, LOAD, S, B, JAL, JALR, LUI, AUIPC)
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3;  in_funct7  in  7
- in_imm  in  32  signed byte offset, or full upper value for LUI/AUIPC
- err_clr  in  1  clears err
- out_valid  out  1  out_instr/out_addr valid
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address of out_instr
- err  out  1  sticky: an unencodable request was seen

## Operation
- Encoding by opcode:
  - R: {funct7, rs2, rs1, funct3, rd, op}.
  - I/LOAD/JALR: {imm[11:0], rs1, funct3, rd, op}.
  - I with funct3 001/101 (shifts): imm[11:5] is taken from funct7; imm[4:0] is taken from in_imm[4:0].
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - LUI/AUIPC: {imm[31:12], rd, op}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - Fields a format does not use are ignored.
- Unknown opcode: the request is consumed, no word is emitted, err is set, and out_addr does not advance.
- Output register: in_ready = !out_valid || out_ready. A request is accepted on in_valid && in_ready. out_valid is loaded with 1 when a good request is accepted, otherwise it clears when the word is taken.
- Address counter: starts at BASE_ADDR and increments by 1 on each output transfer (out_valid && out_ready). It wraps modulo 2^ADDR_W with no flag. out_addr is the current counter value.
- err: set by a bad request, cleared by err_clr. If set and clear happen in the same cycle, set wins.

## Timing
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0. in_ready=1 after reset.
- Latency: a word accepted in cycle N has out_valid=1 in cycle N+1.
- Throughput: 1 word/cycle while out_ready is held high. Accept and drain in the same cycle is allowed.
- While out_valid=1 and out_ready=0: out_instr and out_addr hold stable and in_ready=0.
- A rejected request still takes the single accept slot in its cycle.
- rst asserted mid-stream: the pending word is discarded with no transfer, and the counter returns to BASE_ADDR.

## Configuration
- IMM_RANGE_CHECK_EN defined — range checks applied:
  - I/LOAD/JALR/S: imm in [-2048, 2047].
  - Shift: imm in [0, 31].
  - B: imm in [-4096, 4094] and even.
  - JAL: imm in [-2^20, 2^20-2] and even.
  - LUI/AUIPC: imm[11:0]=0.
  - A failing request is treated like an unknown opcode: consumed, not emitted, err set.
- IMM_RANGE_CHECK_EN undefined: no checks. Out-of-range bits are silently truncated and the word is emitted. err is only set by an unknown opcode.

## Structure
- Shared package riscv_pkg holds:
  - the opcode enum, using the same values the immediate generator uses;
  - the shift funct3 constants.
- One combinational sub-module, instr_pack, does the opcode-to-word packing and produces a valid_fmt/range_ok output.
- The top level holds the handshake register, the address counter and err.

## Test plan
- ADDI x1,x0,5 (op 0x13, rd 1, imm 5) -> 0x00500093 at out_addr 0, one cycle after accept.
- SW x2,8(x1) -> 0x0020A423; BEQ x0,x0,-4 -> 0xFE000EE3; JAL x1,2048 -> 0x001000EF; LUI x5,0x12345000 -> 0x123452B7; addresses 0..3 in order.
- Hold out_ready=0 for 3 cycles with a word pending:
  - out_instr and out_addr stay stable and in_ready=0;
  - on release, exactly one transfer occurs and the address increments once.
- Opcode 0x7F, and with IMM_RANGE_CHECK_EN an ADDI with imm 4096:
  - no out_valid, err=1, address unchanged;
  - err_clr asserted in the same cycle as a new bad request leaves err=1.
- ADDR_W=2, 5 back-to-back transfers with out_ready=1 -> addresses 0,1,2,3,0.
- Assert rst while out_valid=1 and out_ready=0 -> out_valid=0, out_addr=BASE_ADDR and err=0 immediately, without waiting for a clock edge.
